// File: rtl/psp_rvfi_pkg.sv
// psp_rvfi_pkg
//   Shared RVFI definitions. The core's RVFI output, rvfi_trace_buffer and the
//   bench all use this package.
//   RVFI_XLEN    : datapath width of the RVFI fields inside rvfi_pkt_t
//   RVFI_ORDER_W : width of the retire-order tag
//   rvfi_pkt_t   : one retire record
package psp_rvfi_pkg;

  localparam int RVFI_XLEN    = 32;
  localparam int RVFI_ORDER_W = 64;

  typedef struct packed {
    logic [31:0]            insn;
    logic [4:0]             rs1_addr;
    logic [4:0]             rs2_addr;
    logic [RVFI_XLEN-1:0]   rs1_rdata;
    logic [RVFI_XLEN-1:0]   rs2_rdata;
    logic [4:0]             rd_addr;
    logic [RVFI_XLEN-1:0]   rd_wdata;
    logic [RVFI_XLEN-1:0]   pc_rdata;
    logic [RVFI_XLEN-1:0]   pc_wdata;
    logic [RVFI_XLEN-1:0]   mem_addr;
    logic [RVFI_XLEN/8-1:0] mem_rmask;
    logic [RVFI_XLEN/8-1:0] mem_wmask;
    logic [RVFI_XLEN-1:0]   mem_rdata;
    logic [RVFI_XLEN-1:0]   mem_wdata;
  } rvfi_pkt_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with registered storage and a combinational head read.
//   The caller is responsible for only pushing when there is room (or a pop
//   happens in the same cycle) and only popping when count != 0.
//   Ports:
//     clk      : clock, all logic on posedge
//     reset_n  : synchronous active-low reset (pointers and count only)
//     push     : write wdata at the tail
//     pop      : drop the head entry
//     wdata    : entry to write
//     rdata    : current head entry (don't-care while count == 0)
//     count    : occupancy, the authoritative full/empty indicator
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage carries no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/rvfi_trace_buffer.sv
// rvfi_trace_buffer
//   Buffers RVFI retire records between the core and a trace monitor. Every
//   retired instruction is tagged with a 64-bit order number; records that
//   cannot be stored are counted, so gaps in out_order expose drops.
//   Optional feature macro: RVFI_TRACE_STALL_EN
//     defined   : adds core_stall = (count == DEPTH); the core is expected to
//                 stop retiring at full, so in_valid at full is a protocol
//                 error flagged on overflow only (drop_cnt does not move).
//     undefined : no core_stall port; records arriving at full are dropped
//                 and counted in drop_cnt (saturating).
//   Ports:
//     clk        : clock, all logic on posedge
//     reset_n    : synchronous active-low reset
//     in_valid   : core retired one instruction this cycle
//     in_pkt     : retire record
//     out_valid  : head entry available (count != 0)
//     out_ready  : monitor accepts the head entry
//     out_pkt    : head record
//     out_order  : retire order of the head record
//     count      : occupancy
//     overflow   : sticky, set when any record could not be stored
//     drop_cnt   : dropped-record count, saturating
//     core_stall : (RVFI_TRACE_STALL_EN only) buffer full
module rvfi_trace_buffer
  import psp_rvfi_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int XLEN  = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  input  rvfi_pkt_t               in_pkt,
  output logic                    out_valid,
  input  logic                    out_ready,
  output rvfi_pkt_t               out_pkt,
  output logic [RVFI_ORDER_W-1:0] out_order,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic [31:0]             drop_cnt
`ifdef RVFI_TRACE_STALL_EN
  ,
  output logic                    core_stall
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = RVFI_ORDER_W + $bits(rvfi_pkt_t);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

`ifdef RVFI_TRACE_STALL_EN
  localparam bit COUNT_DROPS = 1'b0;
`else
  localparam bit COUNT_DROPS = 1'b1;
`endif

  // The record layout is fixed by the shared package; a mismatched XLEN or a
  // non power-of-two depth would silently corrupt the trace.
  if (XLEN != RVFI_XLEN) begin : g_xlen_check
    $error("rvfi_trace_buffer: XLEN must match psp_rvfi_pkg::RVFI_XLEN");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("rvfi_trace_buffer: DEPTH must be a power of two >= 2");
  end

  logic [RVFI_ORDER_W-1:0] order_q;
  logic                    full;
  logic                    pop;
  logic                    push;
  logic                    reject;
  logic [EW-1:0]           wr_entry;
  logic [EW-1:0]           rd_entry;

  assign full      = (count == FULL_CNT);
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  // A pop in the same cycle frees a slot, so a full buffer still accepts.
  assign push      = in_valid & (~full | pop);
  assign reject    = in_valid & full & ~pop;

  // Tag with the order value before this cycle's increment.
  assign wr_entry             = {order_q, in_pkt};
  assign {out_order, out_pkt} = rd_entry;

`ifdef RVFI_TRACE_STALL_EN
  assign core_stall = full;
`endif

  // Order advances on every retire, stored or not, so drops leave gaps.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      order_q  <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (in_valid) begin
        order_q <= order_q + RVFI_ORDER_W'(1);
      end
      if (reject) begin
        overflow <= 1'b1;
        if (COUNT_DROPS && drop_cnt != 32'hFFFF_FFFF) begin
          drop_cnt <= drop_cnt + 32'd1;
        end
      end
    end
  end

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wdata   (wr_entry),
    .rdata   (rd_entry),
    .count   (count)
  );

endmodule

// File: tb/tb_rvfi_trace_buffer.sv
// tb_rvfi_trace_buffer
//   Self-checking bench for rvfi_trace_buffer (DEPTH=16). A queue-based
//   reference model tracks the buffered records, the retire order, overflow
//   and drop count; DUT outputs are compared on the falling edge.
//   Build with RVFI_TRACE_STALL_EN defined to exercise the stall variant.
module tb_rvfi_trace_buffer;
  import psp_rvfi_pkg::*;

  localparam int DEPTH = 16;

`ifdef RVFI_TRACE_STALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic                    in_valid;
  rvfi_pkt_t               in_pkt;
  logic                    out_valid;
  logic                    out_ready;
  rvfi_pkt_t               out_pkt;
  logic [RVFI_ORDER_W-1:0] out_order;
  logic [$clog2(DEPTH):0]  count;
  logic                    overflow;
  logic [31:0]             drop_cnt;
`ifdef RVFI_TRACE_STALL_EN
  logic                    core_stall;
`endif

  rvfi_trace_buffer #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_pkt    (in_pkt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pkt   (out_pkt),
    .out_order (out_order),
    .count     (count),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
`ifdef RVFI_TRACE_STALL_EN
    ,
    .core_stall(core_stall)
`endif
  );

  always #5 clk = ~clk;

  // Reference model
  typedef struct {
    logic [63:0] ord;
    rvfi_pkt_t   pkt;
  } ent_t;

  ent_t        mq[$];
  logic [63:0] m_order;
  logic        m_ovf;
  logic [31:0] m_drop;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic rvfi_pkt_t rand_pkt();
    rvfi_pkt_t p;
    p.insn      = $urandom;
    p.rs1_addr  = 5'($urandom);
    p.rs2_addr  = 5'($urandom);
    p.rs1_rdata = $urandom;
    p.rs2_rdata = $urandom;
    p.rd_addr   = 5'($urandom);
    p.rd_wdata  = $urandom;
    p.pc_rdata  = $urandom;
    p.pc_wdata  = $urandom;
    p.mem_addr  = $urandom;
    p.mem_rmask = 4'($urandom);
    p.mem_wmask = 4'($urandom);
    p.mem_rdata = $urandom;
    p.mem_wdata = $urandom;
    return p;
  endfunction

  // Apply the retire/accept rules for one clock edge.
  task automatic model_edge(input logic rst_n, input logic iv, input rvfi_pkt_t p, input logic ordy);
    bit do_pop;
    bit is_full;
    if (!rst_n) begin
      mq.delete();
      m_order = '0;
      m_ovf   = 1'b0;
      m_drop  = '0;
    end else begin
      do_pop  = (mq.size() > 0) && ordy;
      is_full = (mq.size() == DEPTH);
      if (do_pop) void'(mq.pop_front());
      if (iv) begin
        if (!is_full || do_pop) begin
          mq.push_back('{ord: m_order, pkt: p});
        end else begin
          m_ovf = 1'b1;
          if (!STALL && m_drop != 32'hFFFF_FFFF) m_drop = m_drop + 1;
        end
        m_order = m_order + 1;
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("count", count, mq.size());
    check_eq("out_valid", out_valid, mq.size() != 0);
    check_eq("overflow", overflow, m_ovf);
    check_eq("drop_cnt", drop_cnt, m_drop);
    if (mq.size() != 0) begin
      check_eq("out_order", out_order, mq[0].ord);
      check_eq("out_pkt", out_pkt, mq[0].pkt);
    end
`ifdef RVFI_TRACE_STALL_EN
    check_eq("core_stall", core_stall, mq.size() == DEPTH);
`endif
  endtask

  // One clock: drive inputs (we are at a falling edge), update the model at
  // the rising edge, compare at the next falling edge.
  task automatic step(input logic iv, input logic ordy);
    rvfi_pkt_t p;
    logic      rst_n;
    p         = rand_pkt();
    in_valid  = iv;
    in_pkt    = p;
    out_ready = ordy;
    @(posedge clk);
    rst_n = reset_n;
    model_edge(rst_n, iv, p, ordy);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic reset_cycles(input int n);
    reset_n = 1'b0;
    for (int i = 0; i < n; i++) step(1'b1, 1'b1);
    reset_n = 1'b1;
  endtask

  initial begin
    int pushes;
    int budget;
    logic [63:0] exp_ord;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_pkt    = '0;
    m_order   = '0;
    m_ovf     = 1'b0;
    m_drop    = '0;
    @(negedge clk);

    // Reset with in_valid held high: nothing stored, order not advanced.
    reset_cycles(2);
    check_eq("rst_count", count, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_ovf", overflow, 0);
    check_eq("rst_drop", drop_cnt, 0);

    // Three isolated retires with the monitor always ready.
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1);
      check_eq("t1_valid", out_valid, 1);
      check_eq("t1_order", out_order, k);
      check_eq("t1_cnt_le1", count <= 1, 1);
      step(1'b0, 1'b1);
      check_eq("t1_cnt_le1", count <= 1, 1);
    end

    // Fill past full with the monitor stalled.
    reset_cycles(1);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0);
`ifdef RVFI_TRACE_STALL_EN
      check_eq("stall_fill", core_stall, i >= 15);
`endif
    end
    check_eq("full_count", count, 16);
    check_eq("full_ovf", overflow, 1);
    check_eq("full_drop", drop_cnt, STALL ? 0 : 4);
    check_eq("full_head", out_order, 0);

    // Push and pop together at full: no drop, count stays 16.
    step(1'b1, 1'b1);
    check_eq("pp_count", count, 16);
    check_eq("pp_drop", drop_cnt, STALL ? 0 : 4);
    check_eq("pp_head", out_order, 1);

    // Drain: orders 1..15 then the entry tagged 20 (16..19 were dropped).
    for (int i = 0; i < 16; i++) begin
      exp_ord = (i < 15) ? 64'(i + 1) : 64'd20;
      check_eq("drain_order", out_order, exp_ord);
      step(1'b0, 1'b1);
`ifdef RVFI_TRACE_STALL_EN
      if (i == 0) check_eq("stall_release", core_stall, 0);
`endif
    end
    check_eq("drain_empty", count, 0);

    // Random traffic with backpressure, many pointer wraps.
    reset_cycles(1);
    pushes = 0;
    budget = 0;
    while (pushes < 80 && budget < 4000) begin
      logic iv;
      logic rd;
      iv = ($urandom_range(0, 99) < 60);
      rd = ($urandom_range(0, 99) < 50);
      if (STALL && mq.size() == DEPTH) iv = 1'b0;
      step(iv, rd);
      if (iv) pushes++;
      budget++;
    end
    check_eq("rand_pushes", pushes >= 40, 1);
    budget = 0;
    while (mq.size() != 0 && budget < 100) begin
      step(1'b0, 1'($urandom_range(0, 1)));
      budget++;
    end
    check_eq("rand_drained", count, 0);

    // Reset with five records buffered.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    check_eq("pre_rst_count", count, 5);
    reset_cycles(1);
    check_eq("mid_rst_count", count, 0);
    check_eq("mid_rst_valid", out_valid, 0);
    step(1'b1, 1'b0);
    check_eq("post_rst_order", out_order, 0);
    check_eq("post_rst_count", count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
